// File: rtl/plru_set_tracker.sv
// Tree pseudo-LRU state for a SETS x WAYS cache: TOUCH updates, VICTIM/VICTIM_FILL select a victim, flush sweeps all sets.
// Latency: the tree update lands at the accept edge; the victim response is registered one cycle after accept.
// Backpressure: op_ready drops during a flush sweep and in any cycle where flush_req is raised.
module plru_set_tracker #(
    parameter int WAYS = 8,
    parameter int SETS = 16,
    localparam int WAY_W = $clog2(WAYS),
    localparam int SET_W = $clog2(SETS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [1:0]       op_code,
    input  logic [SET_W-1:0] op_set,
    input  logic [WAY_W-1:0] op_way,
    input  logic             flush_req,
    output logic             flush_busy,
    output logic             rsp_valid,
    output logic [SET_W-1:0] rsp_set,
    output logic [WAY_W-1:0] rsp_way
);

    localparam logic [1:0] OP_TOUCH  = 2'b00;
    localparam logic [1:0] OP_VICTIM = 2'b01;
    localparam logic [1:0] OP_VFILL  = 2'b10;

    typedef enum logic {ST_IDLE, ST_FLUSH} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SET_W-1:0] r_cnt;
    logic [WAYS-2:0]  r_tree [SETS];

    logic             r_rsp_valid;
    logic [SET_W-1:0] r_rsp_set;
    logic [WAY_W-1:0] r_rsp_way;

    logic             w_acc;
    logic             w_wr;
    logic             w_is_victim;
    logic [WAYS-2:0]  w_cur;
    logic [WAYS-2:0]  w_nxt;
    logic [WAY_W-1:0] w_vic;
    logic [WAY_W-1:0] w_upd_way;

    assign op_ready    = (r_state == ST_IDLE) && !flush_req;
    assign flush_busy  = (r_state == ST_FLUSH);
    assign w_acc       = op_valid && op_ready;
    assign w_is_victim = (op_code == OP_VICTIM) || (op_code == OP_VFILL);
    assign w_wr        = w_acc && ((op_code == OP_TOUCH) || (op_code == OP_VFILL));

    assign rsp_valid = r_rsp_valid;
    assign rsp_set   = r_rsp_set;
    assign rsp_way   = r_rsp_way;

    // Next state: a flush request starts one sweep; the sweep ends after the last set is cleared.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (flush_req) w_state_nxt = ST_FLUSH;
            ST_FLUSH: if (r_cnt == SET_W'(SETS - 1)) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Sweep counter: parked at 0 while idle, so the sweep always starts at set 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    r_cnt <= '0;
        else if (r_state == ST_FLUSH)  r_cnt <= r_cnt + 1'b1;
        else                           r_cnt <= '0;
    end

    // Read the addressed set, walk against the stored directions for the victim, then walk the updated way's path.
    always_comb begin
        int   node;
        logic b;
        w_cur = r_tree[op_set];
        w_vic = '0;
        node  = 0;
        b     = 1'b0;
        for (int k = 0; k < WAY_W; k++) begin
            b = ~w_cur[node];
            w_vic[WAY_W-1-k] = b;
            node = 2 * node + 1 + int'(b);
        end
        w_upd_way = (op_code == OP_TOUCH) ? op_way : w_vic;
        w_nxt = w_cur;
        node  = 0;
        for (int k = 0; k < WAY_W; k++) begin
            b = w_upd_way[WAY_W-1-k];
            w_nxt[node] = b;
            node = 2 * node + 1 + int'(b);
        end
    end

    // Tree storage: the flush sweep clears one set per cycle; ops are never accepted during it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) r_tree[s] <= '0;
        end else if (r_state == ST_FLUSH) begin
            r_tree[r_cnt] <= '0;
        end else if (w_wr) begin
            r_tree[op_set] <= w_nxt;
        end
    end

    // Victim response: one-cycle valid pulse; set/way hold their last value otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_set   <= '0;
            r_rsp_way   <= '0;
        end else begin
            r_rsp_valid <= w_acc && w_is_victim;
            if (w_acc && w_is_victim) begin
                r_rsp_set <= op_set;
                r_rsp_way <= w_vic;
            end
        end
    end

endmodule

// File: tb/tb_plru_set_tracker.sv
// Bench for plru_set_tracker: three instances (8x16, 2x2, 16x64) against a prefix-keyed PLRU model.
// Latency: responses are sampled 1 time unit after the accepting clock edge.
// Backpressure: flush/op collisions and mid-flush reset are exercised on the 8x16 instance.
module tb_plru_set_tracker;

    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   chk_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // instance 0: WAYS=8, SETS=16
    logic       s0_op_valid, s0_op_ready, s0_flush_req, s0_flush_busy, s0_rsp_valid;
    logic [1:0] s0_op_code;
    logic [3:0] s0_op_set, s0_rsp_set;
    logic [2:0] s0_op_way, s0_rsp_way;
    // instance 1: WAYS=2, SETS=2
    logic       s1_op_valid, s1_op_ready, s1_flush_req, s1_flush_busy, s1_rsp_valid;
    logic [1:0] s1_op_code;
    logic [0:0] s1_op_set, s1_rsp_set;
    logic [0:0] s1_op_way, s1_rsp_way;
    // instance 2: WAYS=16, SETS=64
    logic       s2_op_valid, s2_op_ready, s2_flush_req, s2_flush_busy, s2_rsp_valid;
    logic [1:0] s2_op_code;
    logic [5:0] s2_op_set, s2_rsp_set;
    logic [3:0] s2_op_way, s2_rsp_way;

    plru_set_tracker #(.WAYS(8), .SETS(16)) u_d0 (
        .clk(clk), .rst_n(rst_n), .op_valid(s0_op_valid), .op_ready(s0_op_ready),
        .op_code(s0_op_code), .op_set(s0_op_set), .op_way(s0_op_way),
        .flush_req(s0_flush_req), .flush_busy(s0_flush_busy),
        .rsp_valid(s0_rsp_valid), .rsp_set(s0_rsp_set), .rsp_way(s0_rsp_way));

    plru_set_tracker #(.WAYS(2), .SETS(2)) u_d1 (
        .clk(clk), .rst_n(rst_n), .op_valid(s1_op_valid), .op_ready(s1_op_ready),
        .op_code(s1_op_code), .op_set(s1_op_set), .op_way(s1_op_way),
        .flush_req(s1_flush_req), .flush_busy(s1_flush_busy),
        .rsp_valid(s1_rsp_valid), .rsp_set(s1_rsp_set), .rsp_way(s1_rsp_way));

    plru_set_tracker #(.WAYS(16), .SETS(64)) u_d2 (
        .clk(clk), .rst_n(rst_n), .op_valid(s2_op_valid), .op_ready(s2_op_ready),
        .op_code(s2_op_code), .op_set(s2_op_set), .op_way(s2_op_way),
        .flush_req(s2_flush_req), .flush_busy(s2_flush_busy),
        .rsp_valid(s2_rsp_valid), .rsp_set(s2_rsp_set), .rsp_way(s2_rsp_way));

    // Reference model: for each set and tree level, the last direction taken,
    // keyed by the way-prefix that reaches that level.
    bit mb [3][64][4][8];
    int lv   [3] = '{3, 1, 4};
    int nset [3] = '{16, 2, 64};

    function automatic void m_clear(input int inst);
        for (int s = 0; s < 64; s++)
            for (int k = 0; k < 4; k++)
                for (int p = 0; p < 8; p++) mb[inst][s][k][p] = 1'b0;
    endfunction

    function automatic void m_touch(input int inst, input int s, input int w);
        int L = lv[inst];
        for (int k = 0; k < L; k++) mb[inst][s][k][w >> (L - k)] = bit'((w >> (L - 1 - k)) & 1);
    endfunction

    function automatic int m_victim(input int inst, input int s);
        int L = lv[inst];
        int pre = 0;
        for (int k = 0; k < L; k++) pre = pre * 2 + (mb[inst][s][k][pre] ? 0 : 1);
        return pre;
    endfunction

    task automatic drive(input int inst, input bit v, input int code, input int s, input int w);
        case (inst)
            0: begin s0_op_valid = v; s0_op_code = code[1:0]; s0_op_set = s[3:0]; s0_op_way = w[2:0]; end
            1: begin s1_op_valid = v; s1_op_code = code[1:0]; s1_op_set = s[0:0]; s1_op_way = w[0:0]; end
            default: begin s2_op_valid = v; s2_op_code = code[1:0]; s2_op_set = s[5:0]; s2_op_way = w[3:0]; end
        endcase
    endtask

    task automatic do_op(input int code, input int s, input int w);
        drive(0, 1'b1, code, s, w);
        @(posedge clk); #1;
        s0_op_valid = 1'b0;
    endtask

    task automatic test_reset;
        chk_cnt++;
        if ({s0_op_ready, s0_flush_busy, s0_rsp_valid, s0_rsp_set, s0_rsp_way} !== {1'b1, 1'b0, 1'b0, 4'd0, 3'd0})
            $display("FAIL reset_state got ready=%0b busy=%0b rv=%0b set=%0d way=%0d want 1 0 0 0 0",
                     s0_op_ready, s0_flush_busy, s0_rsp_valid, s0_rsp_set, s0_rsp_way);
        else pass_cnt++;
    endtask

    task automatic test_victim_fresh;
        do_op(1, 3, 0);
        chk_cnt++;
        if ({s0_rsp_valid, s0_rsp_set, s0_rsp_way} !== {1'b1, 4'd3, 3'd7})
            $display("FAIL victim_fresh got rv=%0b set=%0d way=%0d want 1 3 7", s0_rsp_valid, s0_rsp_set, s0_rsp_way);
        else pass_cnt++;
        @(posedge clk); #1;
        chk_cnt++;
        if ({s0_rsp_valid, s0_rsp_set, s0_rsp_way} !== {1'b0, 4'd3, 3'd7})
            $display("FAIL rsp_hold got rv=%0b set=%0d way=%0d want 0 3 7", s0_rsp_valid, s0_rsp_set, s0_rsp_way);
        else pass_cnt++;
        do_op(1, 3, 0);
        chk_cnt++;
        if (s0_rsp_way !== 3'd7) $display("FAIL victim_no_update got %0d want 7", s0_rsp_way);
        else pass_cnt++;
    endtask

    task automatic test_touch;
        do_op(0, 3, 5);
        m_touch(0, 3, 5);
        chk_cnt++;
        if (s0_rsp_valid !== 1'b0) $display("FAIL touch_no_rsp got %0b want 0", s0_rsp_valid);
        else pass_cnt++;
        do_op(1, 3, 0);
        chk_cnt++;
        if ({s0_rsp_valid, s0_rsp_way} !== {1'b1, 3'd3})
            $display("FAIL touch_victim got rv=%0b way=%0d want 1 3", s0_rsp_valid, s0_rsp_way);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int seq [8] = '{7, 3, 5, 1, 6, 2, 4, 0};
        for (int i = 0; i < 8; i++) begin
            drive(0, 1'b1, 2, 2, 0);
            m_touch(0, 2, m_victim(0, 2));
            @(posedge clk); #1;
            chk_cnt++;
            if ({s0_rsp_valid, s0_rsp_set, s0_rsp_way} !== {1'b1, 4'd2, 3'(seq[i])})
                $display("FAIL b2b_fill[%0d] got rv=%0b set=%0d way=%0d want 1 2 %0d",
                         i, s0_rsp_valid, s0_rsp_set, s0_rsp_way, seq[i]);
            else pass_cnt++;
        end
        s0_op_valid = 1'b0;
        do_op(1, 4, 0);
        chk_cnt++;
        if (s0_rsp_way !== 3'd7) $display("FAIL b2b_set4 got %0d want 7", s0_rsp_way);
        else pass_cnt++;
    endtask

    task automatic test_flush;
        int n;
        for (int s = 0; s < 16; s++) begin
            int w = $urandom_range(0, 7);
            do_op(0, s, w);
            m_touch(0, s, w);
        end
        drive(0, 1'b1, 1, 5, 0);
        s0_flush_req = 1'b1;
        #1;
        chk_cnt++;
        if (s0_op_ready !== 1'b0) $display("FAIL flush_wins_ready got %0b want 0", s0_op_ready);
        else pass_cnt++;
        @(posedge clk); #1;
        s0_flush_req = 1'b0;
        chk_cnt++;
        if ({s0_flush_busy, s0_rsp_valid} !== 2'b10)
            $display("FAIL flush_entry got busy=%0b rv=%0b want 1 0", s0_flush_busy, s0_rsp_valid);
        else pass_cnt++;
        n = 0;
        while (s0_flush_busy && n < 40) begin
            n++;
            s0_flush_req = (n == 8);
            @(posedge clk); #1;
        end
        s0_flush_req = 1'b0;
        chk_cnt++;
        if (n !== 16) $display("FAIL flush_len got %0d cycles want 16", n);
        else pass_cnt++;
        @(posedge clk); #1;
        s0_op_valid = 1'b0;
        m_clear(0);
        chk_cnt++;
        if ({s0_rsp_valid, s0_rsp_set, s0_rsp_way} !== {1'b1, 4'd5, 3'd7})
            $display("FAIL pending_op got rv=%0b set=%0d way=%0d want 1 5 7", s0_rsp_valid, s0_rsp_set, s0_rsp_way);
        else pass_cnt++;
        for (int s = 0; s < 16; s++) begin
            do_op(1, s, 0);
            chk_cnt++;
            if (s0_rsp_way !== 3'(m_victim(0, s)))
                $display("FAIL flushed_set[%0d] got %0d want %0d", s, s0_rsp_way, m_victim(0, s));
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_midflush;
        do_op(0, 6, 7);
        do_op(0, 15, 0);
        do_op(1, 6, 0);
        chk_cnt++;
        if ({s0_rsp_valid, s0_rsp_way} !== {1'b1, 3'd3})
            $display("FAIL pre_flush_victim got rv=%0b way=%0d want 1 3", s0_rsp_valid, s0_rsp_way);
        else pass_cnt++;
        s0_flush_req = 1'b1;
        @(posedge clk); #1;
        s0_flush_req = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_cnt++;
        if ({s0_flush_busy, s0_rsp_valid, s0_rsp_set, s0_rsp_way, s0_op_ready} !== {1'b0, 1'b0, 4'd0, 3'd0, 1'b1})
            $display("FAIL async_reset got busy=%0b rv=%0b set=%0d way=%0d ready=%0b want 0 0 0 0 1",
                     s0_flush_busy, s0_rsp_valid, s0_rsp_set, s0_rsp_way, s0_op_ready);
        else pass_cnt++;
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) m_clear(i);
        @(posedge clk); #1;
        for (int s = 0; s < 16; s++) begin
            do_op(1, s, 0);
            chk_cnt++;
            if (s0_rsp_way !== 3'd7) $display("FAIL reset_set[%0d] got %0d want 7", s, s0_rsp_way);
            else pass_cnt++;
        end
    endtask

    task automatic test_random(input int inst, input int n);
        int  L = lv[inst];
        int  code, s, w, ev, ew;
        bit  v;
        logic av;
        int  as, aw;
        for (int i = 0; i < n; i++) begin
            v    = ($urandom_range(0, 3) != 0);
            code = $urandom_range(0, 3);
            s    = $urandom_range(0, nset[inst] - 1);
            w    = $urandom_range(0, (1 << L) - 1);
            drive(inst, v, code, s, w);
            ev = 0;
            ew = 0;
            if (v) begin
                if (code == 0) m_touch(inst, s, w);
                else if (code == 1) begin ev = 1; ew = m_victim(inst, s); end
                else if (code == 2) begin ev = 1; ew = m_victim(inst, s); m_touch(inst, s, ew); end
            end
            @(posedge clk); #1;
            case (inst)
                0: begin av = s0_rsp_valid; as = int'(s0_rsp_set); aw = int'(s0_rsp_way); end
                1: begin av = s1_rsp_valid; as = int'(s1_rsp_set); aw = int'(s1_rsp_way); end
                default: begin av = s2_rsp_valid; as = int'(s2_rsp_set); aw = int'(s2_rsp_way); end
            endcase
            chk_cnt++;
            if (av !== 1'(ev) || (ev == 1 && (as != s || aw != ew)))
                $display("FAIL rand_i%0d[%0d] code=%0d got rv=%0b set=%0d way=%0d want rv=%0d set=%0d way=%0d",
                         inst, i, code, av, as, aw, ev, s, ew);
            else pass_cnt++;
        end
        drive(inst, 1'b0, 0, 0, 0);
    endtask

    initial begin
        pass_cnt = 0;
        chk_cnt  = 0;
        rst_n = 1'b0;
        drive(0, 1'b0, 0, 0, 0);
        drive(1, 1'b0, 0, 0, 0);
        drive(2, 1'b0, 0, 0, 0);
        s0_flush_req = 1'b0;
        s1_flush_req = 1'b0;
        s2_flush_req = 1'b0;
        for (int i = 0; i < 3; i++) m_clear(i);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        test_reset();
        test_victim_fresh();
        test_touch();
        test_back_to_back();
        test_flush();
        test_reset_midflush();
        test_random(0, 300);
        test_random(1, 300);
        test_random(2, 600);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
